// File: rtl/phy_cfg_sequencer.sv
// Sequences runtime changes of the PHY Speed/Line_loop_en settings. The MAC is held off
// until TX/RX are quiet, the new settings are applied, and the MAC is released after a settle time.
module phy_cfg_sequencer #(
  parameter logic [2:0] RESET_SPEED = 3'b100,
  parameter int         QUIET_CYC   = 16,
  parameter int         SETTLE_CYC  = 64,
  parameter int         TIMEOUT_CYC = 4096,
  parameter int         CNT_W       = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Cfg_req,
  input  logic [2:0] Cfg_speed,
  input  logic       Cfg_loop_en,
  input  logic       MTxEn,
  input  logic       Rx_dv,
  output logic [2:0] Speed,
  output logic       Line_loop_en,
  output logic       Tx_hold,
  output logic       Cfg_busy,
  output logic       Cfg_done,
  output logic       Cfg_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    APPLY  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] QUIET_LIM   = CNT_W'(QUIET_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LIM  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  state_t           state_q;
  logic [2:0]       speed_q, shadowSpeed_q;
  logic             loop_q, shadowLoop_q;
  logic             txHold_q, busy_q, done_q, err_q;
  logic [CNT_W-1:0] quiet_q, to_q, settle_q;
  logic [CNT_W-1:0] quiet_d, to_d, settle_d;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Any TX or RX activity breaks the quiet run; it has to start over from zero.
  always_comb begin
    quiet_d  = (MTxEn || Rx_dv) ? '0 : satInc(quiet_q);
    to_d     = satInc(to_q);
    settle_d = satInc(settle_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      speed_q       <= RESET_SPEED;
      loop_q        <= 1'b0;
      shadowSpeed_q <= RESET_SPEED;
      shadowLoop_q  <= 1'b0;
      txHold_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      quiet_q       <= '0;
      to_q          <= '0;
      settle_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Cfg_req) begin
            shadowSpeed_q <= Cfg_speed;
            shadowLoop_q  <= Cfg_loop_en;
            busy_q        <= 1'b1;
            if (!$onehot(Cfg_speed)) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else if (Cfg_speed == speed_q && Cfg_loop_en == loop_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= HOLD;
              txHold_q <= 1'b1;
              quiet_q  <= '0;
              to_q     <= '0;
            end
          end
        end
        // A quiet run that completes on the timeout cycle still wins.
        HOLD: begin
          quiet_q <= quiet_d;
          to_q    <= to_d;
          if (quiet_d >= QUIET_LIM) begin
            state_q <= APPLY;
          end else if (to_d >= TIMEOUT_LIM) begin
            state_q  <= ERR;
            txHold_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        APPLY: begin
          speed_q  <= shadowSpeed_q;
          loop_q   <= shadowLoop_q;
          settle_q <= '0;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          settle_q <= settle_d;
          if (settle_d >= SETTLE_LIM) begin
            state_q  <= DONE;
            txHold_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          txHold_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Speed        = speed_q;
  assign Line_loop_en = loop_q;
  assign Tx_hold      = txHold_q;
  assign Cfg_busy     = busy_q;
  assign Cfg_done     = done_q;
  assign Cfg_err      = err_q;

endmodule
